// File: rtl/mnist_result_display_pkg.sv
// mnist_result_display_pkg: shared display constants, types and BCD helper
package mnist_result_display_pkg;
    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;
    localparam seg_t         SEG_BLANK = 7'b1111111;
    localparam seg_t         SEG_DASH  = 7'b0111111;
    localparam logic [3:0]   ANODE_OFF = 4'b1111;
    localparam logic [3:0]   DIGIT_E   = 4'hE;
    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/mnist_result_display_seg.sv
// mnist_result_display_seg: hex to active-low seven-segment decoder {g,f,e,d,c,b,a}
module mnist_result_display_seg
    import mnist_result_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);
    // hex glyph lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/mnist_result_display.sv
// mnist_result_display: latches DNN class, counts inferences in BCD, scans a 4-digit display
module mnist_result_display
    import mnist_result_display_pkg::*;
#(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        clear,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic [11:0] count_bcd,
    output logic [6:0]  segment,
    output logic [3:0]  anode
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [3:0]    r_result;
    logic          r_valid;
    logic          r_err;
    bcd_t          r_ones, r_tens, r_hund;
    logic [DW-1:0] r_div;
    logic [1:0]    r_idx;
    logic [3:0]    r_anode;
    seg_t          r_segment;
    logic [3:0]    w_digit;
    seg_t          w_dec;
    logic          w_slot_blank;
    logic          w_lz_blank;
    seg_t          w_seg_next;
    logic [3:0]    w_anode_next;

    // capture classification and advance the BCD inference count; clear beats a new sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_ones   <= '0;
            r_tens   <= '0;
            r_hund   <= '0;
        end else if (clear) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_ones   <= '0;
            r_tens   <= '0;
            r_hund   <= '0;
        end else if (in_valid) begin
            r_result <= in_data[3:0];
            r_valid  <= 1'b1;
            r_err    <= (|in_data[15:4]) || (in_data[3:0] > 4'd9);
            r_ones   <= bcd_inc(r_ones);
            r_tens   <= (r_ones == 4'd9) ? bcd_inc(r_tens) : r_tens;
            r_hund   <= (r_ones == 4'd9 && r_tens == 4'd9) ? bcd_inc(r_hund) : r_hund;
        end
    end

    // free-running slot divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // digit selection, leading-zero and anti-ghost blanking
    always_comb begin
        w_slot_blank = r_div < DW'(BLANK_CYCLES);
        w_digit      = (r_idx == 2'd0) ? (r_err ? DIGIT_E : r_result) :
                       (r_idx == 2'd1) ? r_ones :
                       (r_idx == 2'd2) ? r_tens : r_hund;
        w_lz_blank   = (r_idx == 2'd2 && r_hund == 4'd0 && r_tens == 4'd0) ||
                       (r_idx == 2'd3 && r_hund == 4'd0);
        w_seg_next   = (w_slot_blank || w_lz_blank) ? SEG_BLANK :
                       (r_idx == 2'd0 && !r_valid) ? SEG_DASH : w_dec;
        w_anode_next = w_slot_blank ? ANODE_OFF : ~(4'b0001 << r_idx);
    end

    mnist_result_display_seg u_seg (
        .i_hex (w_digit),
        .o_seg (w_dec)
    );

    // register display drive so anode and segment change together without glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode   <= ANODE_OFF;
            r_segment <= SEG_BLANK;
        end else begin
            r_anode   <= w_anode_next;
            r_segment <= w_seg_next;
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign count_bcd    = {r_hund, r_tens, r_ones};
    assign segment      = r_segment;
    assign anode        = r_anode;
endmodule
